lc4_regfile: RTL
================

// Module: lc4_regfile
// PURPOSE
// - LC4 general-purpose register file: 8 x 16-bit registers, two combinational read ports, one write port.
// - Sits directly upstream of the ALU and supplies its rs/rt operands (i_r1data, i_r2data).
// - Result write-back (ALU output, load data, PC+1 for JSR/TRAP) returns through the single write port.
// PARAMETERS
// - n        16   data width of each register, in bits
// - NREGS    8    number of registers; power of two, >= 2
// - SELW     3    register-select width; must equal $clog2(NREGS)
// PORTS
// - clk        in   1     the single clock; every state change happens on its rising edge
// - rst        in   1     synchronous, active-high reset; sampled on the rising edge of clk
// - gwe        in   1     global write enable; when 0, no register changes on that edge
// - i_rs       in   SELW  read-port-1 register select
// - o_rs_data  out  n     contents of register i_rs
// - i_rt       in   SELW  read-port-2 register select
// - o_rt_data  out  n     contents of register i_rt
// - i_rd       in   SELW  write-port register select
// - i_wdata    in   n     write data
// - i_rd_we    in   1     write enable for register i_rd
// BEHAVIOUR
// - State: NREGS registers, each n bits. No other state.
// - Reset: a rising edge with rst=1 clears every register to 16'h0000, regardless of gwe and i_rd_we.
// - Outputs follow from this: the first read after the reset edge returns 0 on both ports.
// - Write: at a rising edge with rst=0, gwe=1 and i_rd_we=1, register i_rd <= i_wdata. The value is visible from the next cycle.
// - In every other case all registers hold their value. rst=1 always takes priority over a pending write.
// - Read: o_rs_data and o_rt_data are purely combinational functions of i_rs, i_rt and register state. Latency is 0 cycles.
// - The two read ports are fully independent. i_rs == i_rt is legal; both ports then return the same value.
// - A read selecting i_rd in the same cycle as a write returns the OLD contents unless LC4_REGFILE_BYPASS_EN is set (see CONFIGURATION).
// - All 8 registers are ordinary storage. R7 has no special behaviour here; JSR/TRAP link writes arrive through the normal write port.
// - No arithmetic is done in this block. Widths are exact: i_wdata is stored unmodified, with no truncation or extension.
// - Reset asserted in mid-program: contents are lost at that edge. Reads during the rst=1 cycle still show the pre-reset contents.
// - gwe=0 with i_rd_we=1: no write happens. This is the stall and single-step case.
// CONFIGURATION
// - Macro LC4_REGFILE_BYPASS_EN.
// - Defined: write-before-read bypass. When gwe & i_rd_we & ~rst, each read port whose select equals i_rd outputs i_wdata in that same cycle.
// - Defined: the bypass is suppressed whenever the write itself is suppressed (gwe=0, i_rd_we=0 or rst=1).
// - Not defined: no bypass. Read ports always show the stored contents.
// - Sequential write behaviour is identical either way.
// STRUCTURE
// - Shared package lc4_pkg holds these constants: LC4_W=16, LC4_NREGS=8, LC4_SELW=3, LC4_ZERO=16'h0000.
// - The package also defines the typedef lc4_word_t (logic [15:0]) and lc4_rsel_t (logic [2:0]).
// - Sub-module lc4_reg (parameter n, reset value RST_VAL) is one n-bit register with clk, rst, we, d, q.
// - lc4_reg uses a synchronous active-high reset, and reset has priority over we.
// - The top level instantiates NREGS copies of lc4_reg via generate.
// - Each copy gets we = gwe & i_rd_we & (i_rd == k).
// - Two NREGS:1 read muxes drive the read ports. The optional bypass muxes sit after them.
// TESTING
// - Reset then read: rst=1 for 1 edge, then sweep i_rs/i_rt over 0..7 -> both ports read 16'h0000 for every register.
// - Write/readback: write R3=16'hBEEF, R7=16'h8001 (gwe=1, we=1), then rs=3, rt=7 -> 16'hBEEF / 16'h8001. All other registers still read 0.
// - gwe gating: gwe=0, we=1, rd=2, wdata=16'h1234 -> R2 still 0 next cycle. Repeat with gwe=1 -> R2=16'h1234.
// - Same-cycle read of rd: R5=16'h0011, then write R5=16'h0022 with rs=rt=5 in that cycle.
//   -> Bypass off: both ports read 16'h0011 that cycle and 16'h0022 the next.
//   -> Bypass on: both ports read 16'h0022 in that same cycle.
// - Reset vs write: rst=1 with gwe=1, we=1, rd=1, wdata=16'hFFFF -> R1=0 after the edge. With bypass on, the reads of R1 in that cycle show the old value, not 16'hFFFF.
// - Random: 10k cycles of random selects/data/enables checked against a reference array model, with both macro settings.

Source files
------------

// File: rtl/lc4_pkg.sv
// -----------------------------------------------------------------------------
// lc4_pkg
// Shared LC4 datapath constants and types.
//   LC4_W      : machine word width in bits
//   LC4_NREGS  : number of general-purpose registers
//   LC4_SELW   : register-select width (log2 of LC4_NREGS)
//   LC4_ZERO   : all-zero word, used as the register reset value
//   lc4_word_t : one machine word
//   lc4_rsel_t : one register select
// -----------------------------------------------------------------------------
package lc4_pkg;

  localparam int          LC4_W     = 16;
  localparam int          LC4_NREGS = 8;
  localparam int          LC4_SELW  = 3;
  localparam logic [15:0] LC4_ZERO  = 16'h0000;

  typedef logic [LC4_W-1:0]    lc4_word_t;
  typedef logic [LC4_SELW-1:0] lc4_rsel_t;

endpackage : lc4_pkg

// File: rtl/lc4_reg.sv
// -----------------------------------------------------------------------------
// lc4_reg
// One n-bit storage register with synchronous reset and write enable.
// Reset has priority over the write enable.
// Parameters:
//   n       : data width
//   RST_VAL : value loaded when rst is high at a rising edge
// Ports:
//   clk : clock (rising edge)
//   rst : synchronous active-high reset
//   we  : write enable
//   d   : write data
//   q   : stored value
// -----------------------------------------------------------------------------
module lc4_reg #(
  parameter int           n       = 16,
  parameter logic [n-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [n-1:0] d,
  output logic [n-1:0] q
);

  logic [n-1:0] q_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg <= RST_VAL;
    end else if (we) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule : lc4_reg

// File: rtl/lc4_regfile.sv
// -----------------------------------------------------------------------------
// lc4_regfile
// LC4 general-purpose register file: NREGS x n-bit registers, two
// combinational read ports (rs, rt) and one synchronous write port (rd).
//
// Optional feature, enabled by defining LC4_REGFILE_BYPASS_EN:
//   write-before-read bypass. While a write is actually taking place
//   (gwe & i_rd_we & ~rst), a read port selecting i_rd shows i_wdata in
//   the same cycle. Without the macro the read ports always show the
//   stored contents. Sequential behaviour is the same either way.
//
// Ports:
//   clk       : clock, all state changes on its rising edge
//   rst       : synchronous active-high reset, clears all registers
//   gwe       : global write enable (stall / single-step gating)
//   i_rs      : read-port-1 select      o_rs_data : register i_rs
//   i_rt      : read-port-2 select      o_rt_data : register i_rt
//   i_rd      : write select
//   i_wdata   : write data
//   i_rd_we   : write enable for register i_rd
// -----------------------------------------------------------------------------
module lc4_regfile
  import lc4_pkg::*;
#(
  parameter int n     = LC4_W,
  parameter int NREGS = LC4_NREGS,
  parameter int SELW  = LC4_SELW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            gwe,
  input  logic [SELW-1:0] i_rs,
  output logic [n-1:0]    o_rs_data,
  input  logic [SELW-1:0] i_rt,
  output logic [n-1:0]    o_rt_data,
  input  logic [SELW-1:0] i_rd,
  input  logic [n-1:0]    i_wdata,
  input  logic            i_rd_we
);

  logic [n-1:0] reg_q [NREGS];
  logic [NREGS-1:0] reg_we;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      // One-hot write decode; a register is only touched when selected.
      assign reg_we[gi] = gwe & i_rd_we & (i_rd == SELW'(gi));

      lc4_reg #(
        .n       (n),
        .RST_VAL (n'(LC4_ZERO))
      ) u_reg (
        .clk (clk),
        .rst (rst),
        .we  (reg_we[gi]),
        .d   (i_wdata),
        .q   (reg_q[gi])
      );
    end
  endgenerate

  // Stored-value read muxes.
  logic [n-1:0] rs_stored;
  logic [n-1:0] rt_stored;

  assign rs_stored = reg_q[i_rs];
  assign rt_stored = reg_q[i_rt];

`ifdef LC4_REGFILE_BYPASS_EN
  // The bypass only fires when the write really happens, so a stalled
  // (gwe=0) or reset cycle still shows the stored contents.
  logic wr_active;
  assign wr_active = gwe & i_rd_we & ~rst;

  assign o_rs_data = (wr_active && (i_rs == i_rd)) ? i_wdata : rs_stored;
  assign o_rt_data = (wr_active && (i_rt == i_rd)) ? i_wdata : rt_stored;
`else
  assign o_rs_data = rs_stored;
  assign o_rt_data = rt_stored;
`endif

endmodule : lc4_regfile
